// File: rtl/card_shoe_pkg.sv
// Shared blackjack constants, shoe FSM encoding and the card-value helper.
// Used by the shoe and by its downstream game controller.
package card_shoe_pkg;

    localparam int NUM_RANKS      = 13;
    localparam int RANK_ACE       = 1;
    localparam int FACE_VALUE     = 10;
    localparam int CARDS_PER_DECK = 52;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SHOE_IDLE,
        SHOE_DRAW,
        SHOE_DELIVER,
        SHOE_SHUFFLE
    } shoe_state_e;

    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank > 4'(FACE_VALUE)) ? 4'(FACE_VALUE) : rank;
    endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Request/deal bundle between the game controller (master) and the card shoe (slave).
// Requests are single-cycle pulses; the shoe answers with a one-cycle card_valid.
interface card_shoe_if;

    logic       card_req;
    logic       shuffle_req;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [3:0] card_value;
    logic [7:0] cards_left;
    logic       shoe_empty;
    logic       busy;

    modport master (
        output card_req, shuffle_req,
        input  card_valid, card_rank, card_value, cards_left, shoe_empty, busy
    );

    modport slave (
        input  card_req, shuffle_req,
        output card_valid, card_rank, card_value, cards_left, shoe_empty, busy
    );

endinterface

// File: rtl/card_shoe_lfsr16.sv
// Free-running 16-bit Galois LFSR, advances every cycle from SEED.
// Latency: state visible one cycle after each shift; no backpressure.
module card_shoe_lfsr16
    import card_shoe_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]};
        if (state_q[0]) begin
            state_d = state_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/card_shoe.sv
// Finite card shoe: deals one card per card_req from per-rank counts, refills on shuffle_req.
// Latency 2..14 cycles per card; requests while busy are dropped, shuffles while busy are deferred.
module card_shoe
    import card_shoe_pkg::*;
#(
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    card_shoe_if.slave  bus
);

    localparam int              RANK_FULL = 4 * NUM_DECKS;
    localparam int              CW        = $clog2(RANK_FULL + 1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(RANK_FULL);
    localparam logic [7:0]      SHOE_FULL = 8'(CARDS_PER_DECK * NUM_DECKS);
    localparam logic [3:0]      LAST_IDX  = 4'(NUM_RANKS - 1);

    shoe_state_e    state_q, state_d;
    logic [CW-1:0]  cnt_q [NUM_RANKS];
    logic [CW-1:0]  cnt_d [NUM_RANKS];
    logic [3:0]     cand_q, cand_d;
    logic [3:0]     rank_q, rank_d;
    logic [3:0]     value_q, value_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     left_q, left_d;
    logic           pend_q, pend_d;

    logic [15:0]    lfsr;
    logic [3:0]     cand_idx;
    logic           unused_lfsr_hi;

    card_shoe_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .state_o  (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:4];
    assign cand_idx       = cand_q - 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        rank_d  = rank_q;
        value_d = value_q;
        idx_d   = idx_q;
        left_d  = left_q;
        pend_d  = pend_q | bus.shuffle_req;

        unique case (state_q)
            SHOE_IDLE: begin
                if (bus.shuffle_req || pend_q) begin
                    idx_d   = 4'd0;
                    state_d = SHOE_SHUFFLE;
                end else if (bus.card_req && (left_q != 8'd0)) begin
                    // fold 13..15 back onto 1..3 so every nibble maps to a rank
                    cand_d  = (lfsr[3:0] < 4'(NUM_RANKS)) ? (lfsr[3:0] + 4'd1)
                                                          : (lfsr[3:0] - 4'(NUM_RANKS - 1));
                    state_d = SHOE_DRAW;
                end
            end
            SHOE_DRAW: begin
                if (cnt_q[cand_idx] != '0) begin
                    cnt_d[cand_idx] = cnt_q[cand_idx] - CW'(1);
                    left_d          = left_q - 8'd1;
                    rank_d          = cand_q;
                    value_d         = card_value(cand_q);
                    state_d         = SHOE_DELIVER;
                end else begin
                    // left_q was non-zero on entry, so this walk hits a card within 13 probes
                    cand_d = (cand_q == 4'(NUM_RANKS)) ? 4'(RANK_ACE) : (cand_q + 4'd1);
                end
            end
            SHOE_DELIVER: begin
                state_d = SHOE_IDLE;
            end
            SHOE_SHUFFLE: begin
                cnt_d[idx_q] = CNT_FULL;
                if (idx_q == LAST_IDX) begin
                    left_d  = SHOE_FULL;
                    pend_d  = 1'b0;
                    state_d = SHOE_IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = SHOE_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= SHOE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                cnt_q[r] <= CNT_FULL;
            end
            cand_q  <= 4'd0;
            rank_q  <= 4'd0;
            value_q <= 4'd0;
            idx_q   <= 4'd0;
            left_q  <= SHOE_FULL;
            pend_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            rank_q  <= rank_d;
            value_q <= value_d;
            idx_q   <= idx_d;
            left_q  <= left_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.card_valid = (state_q == SHOE_DELIVER);
    assign bus.card_rank  = rank_q;
    assign bus.card_value = value_q;
    assign bus.cards_left = left_q;
    assign bus.shoe_empty = (left_q == 8'd0);
    assign bus.busy       = (state_q != SHOE_IDLE);

endmodule

// File: tb/tb_card_shoe.sv
// Randomly spaced deal/shuffle traffic against a per-rank count model of a single-deck shoe.
module tb_card_shoe;

    logic clk = 1'b0;
    logic rst_n;

    card_shoe_if sh();

    card_shoe #(.NUM_DECKS(1), .LFSR_SEED(16'hACE1)) dut (
        .CLOCK_50 (clk),
        .resetn   (rst_n),
        .bus      (sh.slave)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mcnt [1:13];
    int mleft;

    function automatic int exp_value(input int r);
        return (r > 10) ? 10 : r;
    endfunction

    task automatic model_fill();
        for (int r = 1; r <= 13; r++) mcnt[r] = 4;
        mleft = 52;
    endtask

    function automatic int ranks_in_model();
        int n = 0;
        for (int r = 1; r <= 13; r++) if (mcnt[r] != 0) n++;
        return n;
    endfunction

    // Pulses card_req at a negedge and returns how many negedges until card_valid (40 = timed out).
    task automatic deal_one(output int lat);
        sh.card_req = 1'b1;
        @(negedge clk);
        sh.card_req = 1'b0;
        lat = 1;
        while (!sh.card_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_idle(output int busy_cycles, output int valids);
        busy_cycles = 0;
        valids      = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sh.busy) busy_cycles++;
            if (sh.card_valid) valids++;
        end
    endtask

    task automatic test_reset();
        sh.card_req    = 1'b0;
        sh.shuffle_req = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sh.card_rank !== 4'd0 || sh.card_value !== 4'd0 || sh.card_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rank=%0d value=%0d valid=%b, want 0 0 0",
                     sh.card_rank, sh.card_value, sh.card_valid);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (sh.card_valid !== 1'b0 || sh.busy !== 1'b0 || sh.shoe_empty !== 1'b0 ||
                sh.cards_left !== 8'd52) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: valid=%b busy=%b empty=%b left=%0d, want 0 0 0 52",
                         i, sh.card_valid, sh.busy, sh.shoe_empty, sh.cards_left);
            end
        end
        model_fill();
    endtask

    task automatic test_full_deal();
        int lat;
        int r;
        int sum = 0;
        logic [3:0] held;
        for (int n = 0; n < 52; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            deal_one(lat);
            checks++;
            if (lat < 2 || lat > 14) begin
                errors++;
                $display("FAIL deal_latency card %0d: got %0d cycles, want 2..14", n, lat);
            end
            r = int'(sh.card_rank);
            checks++;
            if (r < 1 || r > 13 || mcnt[r] == 0) begin
                errors++;
                $display("FAIL deal_rank card %0d: got rank %0d, want a rank still in the shoe", n, r);
            end else begin
                mcnt[r]--;
                mleft--;
                sum += exp_value(r);
            end
            checks++;
            if (sh.card_value !== 4'(exp_value(r))) begin
                errors++;
                $display("FAIL deal_value card %0d: got %0d, want %0d", n, sh.card_value, exp_value(r));
            end
            checks++;
            if (sh.cards_left !== 8'(mleft) || sh.shoe_empty !== (mleft == 0)) begin
                errors++;
                $display("FAIL deal_left card %0d: left=%0d empty=%b, want %0d %b",
                         n, sh.cards_left, sh.shoe_empty, mleft, (mleft == 0));
            end
            held = sh.card_rank;
            @(negedge clk);
            checks++;
            if (sh.card_valid !== 1'b0 || sh.card_rank !== held) begin
                errors++;
                $display("FAIL deal_pulse card %0d: valid=%b rank=%0d, want 0 %0d",
                         n, sh.card_valid, sh.card_rank, held);
            end
        end
        checks++;
        if (sum != 340) begin
            errors++;
            $display("FAIL deal_value_sum: got %0d, want 340", sum);
        end
        checks++;
        if (ranks_in_model() != 0 || sh.cards_left !== 8'd0 || sh.shoe_empty !== 1'b1) begin
            errors++;
            $display("FAIL deal_exhaust: ranks left %0d, left=%0d empty=%b, want 0 0 1",
                     ranks_in_model(), sh.cards_left, sh.shoe_empty);
        end
    endtask

    task automatic test_empty_req();
        int busy_cycles;
        int valids;
        sh.card_req = 1'b1;
        @(negedge clk);
        sh.card_req = 1'b0;
        busy_cycles = 0;
        valids      = 0;
        for (int i = 0; i < 30; i++) begin
            if (sh.busy) busy_cycles++;
            if (sh.card_valid) valids++;
            @(negedge clk);
        end
        checks++;
        if (valids != 0 || busy_cycles != 0) begin
            errors++;
            $display("FAIL empty_req: valids=%0d busy cycles=%0d, want 0 0", valids, busy_cycles);
        end
    endtask

    task automatic test_shuffle_collision();
        int busy_cycles;
        int valids;
        logic [3:0] rank_before;
        logic [3:0] value_before;
        rank_before    = sh.card_rank;
        value_before   = sh.card_value;
        sh.card_req    = 1'b1;
        sh.shuffle_req = 1'b1;
        @(negedge clk);
        sh.card_req    = 1'b0;
        sh.shuffle_req = 1'b0;
        busy_cycles = sh.busy ? 1 : 0;
        valids      = sh.card_valid ? 1 : 0;
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            if (sh.busy) busy_cycles++;
            if (sh.card_valid) valids++;
        end
        checks++;
        if (busy_cycles != 13 || valids != 0) begin
            errors++;
            $display("FAIL shuffle_collision: busy cycles=%0d valids=%0d, want 13 0", busy_cycles, valids);
        end
        checks++;
        if (sh.cards_left !== 8'd52 || sh.shoe_empty !== 1'b0) begin
            errors++;
            $display("FAIL shuffle_refill: left=%0d empty=%b, want 52 0", sh.cards_left, sh.shoe_empty);
        end
        checks++;
        if (sh.card_rank !== rank_before || sh.card_value !== value_before) begin
            errors++;
            $display("FAIL shuffle_keeps_card: rank=%0d value=%0d, want %0d %0d",
                     sh.card_rank, sh.card_value, rank_before, value_before);
        end
        model_fill();
    endtask

    task automatic test_one_rank_left();
        int lat;
        int r;
        int last;
        int remain;
        for (int n = 0; n < 60 && ranks_in_model() > 1; n++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            deal_one(lat);
            r = int'(sh.card_rank);
            checks++;
            if (lat > 14 || r < 1 || r > 13 || mcnt[r] == 0) begin
                errors++;
                $display("FAIL drain_card %0d: latency=%0d rank=%0d, want <=14 and a rank still in the shoe",
                         n, lat, r);
            end else begin
                mcnt[r]--;
                mleft--;
            end
        end
        last = 0;
        for (int k = 1; k <= 13; k++) if (mcnt[k] != 0) last = k;
        remain = (last != 0) ? mcnt[last] : 0;
        for (int n = 0; n < remain; n++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            deal_one(lat);
            checks++;
            if (lat < 2 || lat > 14 || sh.card_rank !== 4'(last) ||
                sh.card_value !== 4'(exp_value(last)) || sh.cards_left !== 8'(mleft - 1)) begin
                errors++;
                $display("FAIL last_rank_probe: latency=%0d rank=%0d value=%0d left=%0d, want 2..14 %0d %0d %0d",
                         lat, sh.card_rank, sh.card_value, sh.cards_left, last, exp_value(last), mleft - 1);
            end
            mcnt[last]--;
            mleft--;
        end
        @(negedge clk);
        checks++;
        if (sh.cards_left !== 8'd0 || sh.shoe_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: left=%0d empty=%b, want 0 1", sh.cards_left, sh.shoe_empty);
        end
    endtask

    task automatic test_shuffle_during_draw();
        int busy_cycles;
        int valids;
        int lat;
        int r;
        sh.shuffle_req = 1'b1;
        @(negedge clk);
        sh.shuffle_req = 1'b0;
        wait_idle(busy_cycles, valids);
        checks++;
        if (sh.cards_left !== 8'd52 || busy_cycles != 12 || valids != 0) begin
            errors++;
            $display("FAIL plain_shuffle: left=%0d busy after pulse=%0d valids=%0d, want 52 12 0",
                     sh.cards_left, busy_cycles, valids);
        end
        model_fill();
        sh.card_req = 1'b1;
        @(negedge clk);
        sh.card_req    = 1'b0;
        sh.shuffle_req = 1'b1;
        @(negedge clk);
        sh.shuffle_req = 1'b0;
        lat = 2;
        while (!sh.card_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = int'(sh.card_rank);
        checks++;
        if (lat > 14 || r < 1 || r > 13 || sh.cards_left !== 8'd51) begin
            errors++;
            $display("FAIL draw_before_shuffle: latency=%0d rank=%0d left=%0d, want <=14 1..13 51",
                     lat, r, sh.cards_left);
        end
        wait_idle(busy_cycles, valids);
        checks++;
        if (busy_cycles != 13 || valids != 0 || sh.cards_left !== 8'd52) begin
            errors++;
            $display("FAIL deferred_shuffle: busy cycles=%0d valids=%0d left=%0d, want 13 0 52",
                     busy_cycles, valids, sh.cards_left);
        end
        model_fill();
    endtask

    task automatic test_reset_mid_draw();
        int valids;
        sh.card_req = 1'b1;
        @(negedge clk);
        sh.card_req = 1'b0;
        checks++;
        if (sh.busy !== 1'b1 || sh.card_valid !== 1'b0) begin
            errors++;
            $display("FAIL draw_entry: busy=%b valid=%b, want 1 0", sh.busy, sh.card_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sh.card_valid !== 1'b0 || sh.busy !== 1'b0 || sh.cards_left !== 8'd52 ||
            sh.card_rank !== 4'd0 || sh.card_value !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b left=%0d rank=%0d value=%0d, want 0 0 52 0 0",
                     sh.card_valid, sh.busy, sh.cards_left, sh.card_rank, sh.card_value);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        valids = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sh.card_valid) valids++;
        end
        checks++;
        if (valids != 0 || sh.cards_left !== 8'd52 || sh.busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: valids=%0d left=%0d busy=%b, want 0 52 0",
                     valids, sh.cards_left, sh.busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_deal();
        test_empty_req();
        test_shuffle_collision();
        test_one_rank_left();
        test_shuffle_during_draw();
        test_reset_mid_draw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
